// File: rtl/param_add_unit.sv
// ---------------------------------------------------------------------------
// param_add_unit
//
// Two-stage pipelined add/subtract/accumulate unit with valid/ready
// handshakes on both sides. Stage 1 captures the operation and operands.
// Stage 2 computes the result and holds it until the consumer takes it.
// The SAT parameter chooses between saturating and modular arithmetic.
//
// Parameters
//   WIDTH   operand/result width in bits (2..32)
//   SAT     1 = saturating results, 0 = modular wrap
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand transaction offered
//   in_ready   unit can accept a transaction this cycle
//   op         00 ADD, 01 SUB, 10 ACC, 11 CLR
//   a, b       operands (b ignored for ACC and CLR)
//   out_valid  result available
//   out_ready  consumer accepts the result
//   y          result
//   cy         carry (ADD/ACC), borrow (SUB), 0 for CLR
//   txn_cnt    count of accepted input transactions (wraps)
// ---------------------------------------------------------------------------
module param_add_unit #(
    parameter int WIDTH = 4,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cy,
    output logic [15:0]      txn_cnt
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    localparam bit SAT_EN = (SAT != 0);

    // Stage 1 registers
    logic             r_s1Valid;
    op_e              r_s1Op;
    logic [WIDTH-1:0] r_s1A;
    logic [WIDTH-1:0] r_s1B;

    // Stage 2 registers and architectural state
    logic             r_outValid;
    logic [WIDTH-1:0] r_y;
    logic             r_cy;
    logic [WIDTH-1:0] r_acc;
    logic [15:0]      r_txnCnt;

    // Handshake and datapath wires
    logic             w_s2Ready;
    logic             w_advance;
    logic             w_accept;
    logic [WIDTH:0]   w_opSum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_accSum;
    logic [WIDTH-1:0] w_y;
    logic             w_cy;
    logic [WIDTH-1:0] w_accNext;

    // Stage 2 can take new data when it is empty or its result is leaving.
    // Stage 1 can take new data when it is empty or it is moving into
    // stage 2, which makes in_ready independent of in_valid.
    assign w_s2Ready = !r_outValid || out_ready;
    assign w_advance = r_s1Valid && w_s2Ready;
    assign in_ready  = !r_s1Valid || !r_outValid || out_ready;
    assign w_accept  = in_valid && in_ready;

    // The extra top bit of the difference is the borrow, i.e. a < b.
    assign w_opSum  = {1'b0, r_s1A} + {1'b0, r_s1B};
    assign w_diff   = {1'b0, r_s1A} - {1'b0, r_s1B};
    assign w_accSum = {1'b0, r_acc} + {1'b0, r_s1A};

    // Result computation for the operation sitting in stage 1. The
    // accumulator's next value is the ACC result itself, so a saturated
    // accumulator stays at all-ones until a CLR arrives.
    always_comb begin
        w_y       = '0;
        w_cy      = 1'b0;
        w_accNext = r_acc;
        unique case (r_s1Op)
            OP_ADD: begin
                w_cy = w_opSum[WIDTH];
                w_y  = (SAT_EN && w_cy) ? '1 : w_opSum[WIDTH-1:0];
            end
            OP_SUB: begin
                w_cy = w_diff[WIDTH];
                w_y  = (SAT_EN && w_cy) ? '0 : w_diff[WIDTH-1:0];
            end
            OP_ACC: begin
                w_cy      = w_accSum[WIDTH];
                w_y       = (SAT_EN && w_cy) ? '1 : w_accSum[WIDTH-1:0];
                w_accNext = w_y;
            end
            OP_CLR: begin
                w_y       = '0;
                w_cy      = 1'b0;
                w_accNext = '0;
            end
            default: begin
                w_y       = '0;
                w_cy      = 1'b0;
                w_accNext = r_acc;
            end
        endcase
    end

    // Stage 1: whenever it has room it reloads from the input side, so an
    // idle input cycle simply empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1Op    <= OP_ADD;
            r_s1A     <= '0;
            r_s1B     <= '0;
        end else if (in_ready) begin
            r_s1Valid <= in_valid;
            if (in_valid) begin
                r_s1Op <= op_e'(op);
                r_s1A  <= a;
                r_s1B  <= b;
            end
        end
    end

    // Stage 2 and accumulator: everything freezes while the result is
    // stalled. The accumulator only changes as its transaction moves on,
    // so back-to-back ACCs each see the previous result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_y        <= '0;
            r_cy       <= 1'b0;
            r_acc      <= '0;
        end else if (w_s2Ready) begin
            r_outValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_y   <= w_y;
                r_cy  <= w_cy;
                r_acc <= w_accNext;
            end
        end
    end

    // Accepted-transaction counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txnCnt <= '0;
        end else if (w_accept) begin
            r_txnCnt <= r_txnCnt + 16'd1;
        end
    end

    assign out_valid = r_outValid;
    assign y         = r_y;
    assign cy        = r_cy;
    assign txn_cnt   = r_txnCnt;

endmodule

// File: tb/tb_param_add_unit.sv
// ---------------------------------------------------------------------------
// tb_param_add_unit
//
// Drives a modular (SAT=0) and a saturating (SAT=1) instance with identical
// stimulus. Expected results are produced by a behavioural model when a
// transaction is accepted, queued per instance, and compared in order when
// each instance hands a result to the consumer.
// ---------------------------------------------------------------------------
module tb_param_add_unit;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] y;
        logic         cy;
    } res_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_ready;

    logic         inReady0, inReady1;
    logic         outValid0, outValid1;
    logic [W-1:0] y0, y1;
    logic         cy0, cy1;
    logic [15:0]  txnCnt0, txnCnt1;

    int           compared;
    int           mismatched;

    res_t         q0[$];
    res_t         q1[$];
    int           modelAcc0;
    int           modelAcc1;
    logic [15:0]  modelCnt;

    logic         prevStall0, prevStall1;
    logic [W-1:0] prevY0, prevY1;
    logic         prevCy0, prevCy1;

    param_add_unit #(.WIDTH(W), .SAT(0)) dutWrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (inReady0),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (outValid0),
        .out_ready (out_ready),
        .y         (y0),
        .cy        (cy0),
        .txn_cnt   (txnCnt0)
    );

    param_add_unit #(.WIDTH(W), .SAT(1)) dutSat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (inReady1),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (outValid1),
        .out_ready (out_ready),
        .y         (y1),
        .cy        (cy1),
        .txn_cnt   (txnCnt1)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one operation for a 4-bit unit
    task automatic modelOp(input logic [1:0] o, input int av, input int bv, input bit sat,
                           inout int acc, output int yv, output int cyv);
        int s;
        case (o)
            2'd0: begin
                s   = av + bv;
                cyv = (s > 15) ? 1 : 0;
                yv  = (cyv != 0) ? (sat ? 15 : s - 16) : s;
            end
            2'd1: begin
                cyv = (av < bv) ? 1 : 0;
                yv  = (cyv != 0) ? (sat ? 0 : av - bv + 16) : av - bv;
            end
            2'd2: begin
                s   = acc + av;
                cyv = (s > 15) ? 1 : 0;
                acc = (cyv != 0) ? (sat ? 15 : s - 16) : s;
                yv  = acc;
            end
            default: begin
                acc = 0;
                yv  = 0;
                cyv = 0;
            end
        endcase
    endtask

    // Scoreboard monitor, sampled on the falling edge: the handshakes seen
    // here are the ones that complete on the following rising edge.
    always @(negedge clk) begin
        res_t e;
        int   yv;
        int   cyv;
        if (rst_n) begin
            if (prevStall0) begin
                checkOutput("stallValid0", {31'd0, outValid0}, 32'd1);
                checkOutput("stallY0", {28'd0, y0}, {28'd0, prevY0});
                checkOutput("stallCy0", {31'd0, cy0}, {31'd0, prevCy0});
            end
            if (prevStall1) begin
                checkOutput("stallY1", {28'd0, y1}, {28'd0, prevY1});
                checkOutput("stallCy1", {31'd0, cy1}, {31'd0, prevCy1});
            end
            prevStall0 = outValid0 && !out_ready;
            prevStall1 = outValid1 && !out_ready;
            prevY0     = y0;
            prevY1     = y1;
            prevCy0    = cy0;
            prevCy1    = cy1;

            checkOutput("inReadyMatch", {31'd0, inReady1}, {31'd0, inReady0});

            if (outValid0 && out_ready) begin
                checkOutput("resultExpected0", {31'd0, (q0.size() > 0)}, 32'd1);
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    checkOutput("y0", {28'd0, y0}, {28'd0, e.y});
                    checkOutput("cy0", {31'd0, cy0}, {31'd0, e.cy});
                end
            end
            if (outValid1 && out_ready) begin
                checkOutput("resultExpected1", {31'd0, (q1.size() > 0)}, 32'd1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    checkOutput("y1", {28'd0, y1}, {28'd0, e.y});
                    checkOutput("cy1", {31'd0, cy1}, {31'd0, e.cy});
                end
            end
            if (in_valid && inReady0) begin
                modelOp(op, int'(a), int'(b), 1'b0, modelAcc0, yv, cyv);
                e.y  = yv[W-1:0];
                e.cy = cyv[0];
                q0.push_back(e);
                modelOp(op, int'(a), int'(b), 1'b1, modelAcc1, yv, cyv);
                e.y  = yv[W-1:0];
                e.cy = cyv[0];
                q1.push_back(e);
                modelCnt = modelCnt + 16'd1;
            end
        end else begin
            prevStall0 = 1'b0;
            prevStall1 = 1'b0;
        end
    end

    // Offer one transaction and hold it until the unit accepts it; returns
    // just after the accepting edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        bit took;
        bit done;
        in_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
        done     = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            took = inReady0;
            @(posedge clk);
            #1;
            if (took) done = 1'b1;
        end
        if (!done) checkOutput("acceptTimeout", 32'd0, 32'd1);
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 100; k++) begin
            if (q0.size() == 0 && q1.size() == 0 && !outValid0 && !outValid1) break;
            @(posedge clk);
            #1;
        end
        checkOutput("drainPending", q0.size() + q1.size(), 32'd0);
    endtask

    task automatic applyReset();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        modelAcc0 = 0;
        modelAcc1 = 0;
        modelCnt  = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit sawBlocked;
        bit took;
        int idx;
        compared   = 0;
        mismatched = 0;
        modelAcc0  = 0;
        modelAcc1  = 0;
        modelCnt   = 16'd0;
        prevStall0 = 1'b0;
        prevStall1 = 1'b0;
        prevY0     = '0;
        prevY1     = '0;
        prevCy0    = 1'b0;
        prevCy1    = 1'b0;
        in_valid   = 1'b0;
        op         = 2'd0;
        a          = '0;
        b          = '0;
        out_ready  = 1'b1;
        rst_n      = 1'b1;

        // Reset values appear asynchronously
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstOutValid", {31'd0, outValid0}, 32'd0);
        checkOutput("rstY", {28'd0, y0}, 32'd0);
        checkOutput("rstCy", {31'd0, cy0}, 32'd0);
        checkOutput("rstTxnCnt", {16'd0, txnCnt0}, 32'd0);
        checkOutput("rstInReady", {31'd0, inReady0}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("releaseInReady", {31'd0, inReady0}, 32'd1);

        // Latency: result visible after the second rising edge
        applyStimulus(2'd0, 4'd7, 4'd5);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("latencyStage1", {31'd0, outValid0}, 32'd0);
        @(negedge clk);
        checkOutput("latencyStage2", {31'd0, outValid0}, 32'd1);
        checkOutput("add7p5", {28'd0, y0}, 32'd12);

        // Directed ADD / SUB / CLR / ACC sequence, back to back
        applyStimulus(2'd0, 4'd9, 4'd8);
        applyStimulus(2'd1, 4'd3, 4'd5);
        applyStimulus(2'd1, 4'd5, 4'd3);
        applyStimulus(2'd3, 4'd0, 4'd0);
        applyStimulus(2'd2, 4'd6, 4'd9);
        applyStimulus(2'd2, 4'd6, 4'd9);
        applyStimulus(2'd2, 4'd6, 4'd9);
        applyStimulus(2'd2, 4'd1, 4'd0);
        in_valid = 1'b0;
        waitDrain();
        checkOutput("accFinalWrap", {28'd0, y0}, 32'd3);
        checkOutput("accFinalSat", {28'd0, y1}, 32'd15);
        checkOutput("accFinalSatCy", {31'd0, cy1}, 32'd1);
        checkOutput("txnCntDirected", {16'd0, txnCnt0}, {16'd0, modelCnt});

        // Random stream with a three-cycle consumer stall
        applyReset();
        sawBlocked = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 100 && idx < 10; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 7);
            in_valid  = 1'b1;
            op        = 2'($urandom_range(0, 3));
            if (cyc == 0 || took) begin
                a = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            took = inReady0;
            if (!took) sawBlocked = 1'b1;
            @(posedge clk);
            #1;
            if (took) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitDrain();
        checkOutput("streamAccepted", idx, 32'd10);
        checkOutput("streamBackpressure", {31'd0, sawBlocked}, 32'd1);
        checkOutput("streamTxnCnt", {16'd0, txnCnt0}, 32'd10);

        // Reset with two transactions in flight
        applyReset();
        applyStimulus(2'd0, 4'd3, 4'd4);
        applyStimulus(2'd0, 4'd2, 4'd2);
        in_valid = 1'b0;
        checkOutput("inFlightValid", {31'd0, outValid0}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstValid", {31'd0, outValid0}, 32'd0);
        checkOutput("midRstY", {28'd0, y0}, 32'd0);
        checkOutput("midRstTxnCnt", {16'd0, txnCnt0}, 32'd0);
        q0.delete();
        q1.delete();
        modelAcc0 = 0;
        modelAcc1 = 0;
        modelCnt  = 16'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("midRstInReady", {31'd0, inReady0}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("noGhostOutput", {31'd0, outValid0}, 32'd0);
        applyStimulus(2'd0, 4'd1, 4'd1);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("postRstAdd", {28'd0, y0}, 32'd2);
        waitDrain();

        // Counter wrap after 65537 transactions
        applyReset();
        for (int n = 0; n < 65537; n++) begin
            applyStimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        in_valid = 1'b0;
        waitDrain();
        checkOutput("txnCntWrap0", {16'd0, txnCnt0}, 32'd1);
        checkOutput("txnCntWrap1", {16'd0, txnCnt1}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
